sample_loader: RTL and testbench

Upstream stage of `linear_regression`: collects operator-entered sample pairs (x_i, y_i) one value at a time from `data_in`, qualified by the `enter` button. It packs them into the X design matrix (column 1 constant 1) and the y vector in the layout `matrix_transpose` and `matrix_multiply` consume. When the set is complete and confirmed with `input_done`, it signals `ready`. It replaces the hard-coded `input_matrix` stub and keeps the same port names.

---
 rtl/linreg_pkg.sv | 24 ++
 rtl/rise_detect.sv | 32 +++
 rtl/sample_loader.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_sample_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/linreg_pkg.sv
// ---------------------------------------------------------------------------
// linreg_pkg
// Shared definitions for the linear_regression pipeline.
//   loader_state_t  : state encoding of the sample_loader control FSM
//   ELEM_WIDTH_DEF  : default element width used across the pipeline
//   NUM_SAMPLES_DEF : default number of (x, y) sample pairs per data set
//   ONE_ELEM        : constant 1 at the default element width (X column 1)
// ---------------------------------------------------------------------------
package linreg_pkg;

  localparam int ELEM_WIDTH_DEF  = 14;
  localparam int NUM_SAMPLES_DEF = 3;

  localparam logic [ELEM_WIDTH_DEF-1:0] ONE_ELEM = 14'd1;

  typedef enum logic [2:0] {
    LOAD_X = 3'd0,
    LOAD_Y = 3'd1,
    FULL   = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } loader_state_t;

endpackage

// File: rtl/rise_detect.sv
// ---------------------------------------------------------------------------
// rise_detect
// Rising-edge detector for a button level: one delay register plus AND.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset (clears the delay register)
//   sig  : input level
//   rise : high in the cycle where sig is 1 and was 0 on the previous edge
// ---------------------------------------------------------------------------
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q_r;

  // Delay register holding the previous sampled level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q_r <= 1'b0;
    end else begin
      sig_q_r <= sig;
    end
  end

  // A level already high when reset releases still reads as an edge,
  // because the delay register comes out of reset at 0.
  assign rise = sig & ~sig_q_r;

endmodule

// File: rtl/sample_loader.sv
// ---------------------------------------------------------------------------
// sample_loader
// Collects operator-entered (x_i, y_i) sample pairs one value at a time and
// packs them into the X design matrix (column 1 = constant 1) and y vector
// consumed by matrix_transpose / matrix_multiply.
//
// Ports:
//   clk        : clock, all logic on its rising edge
//   rst        : asynchronous active-high reset
//   enter      : button level, each rising edge captures data_in
//   input_done : button level, each rising edge confirms / aborts the set
//   data_in    : unsigned value sampled on the enter edge cycle
//   x_data     : element (2i+j) at [(2i+j)*ELEM_WIDTH +: ELEM_WIDTH],
//                j=0 -> x_i, j=1 -> constant 1
//   y_data     : y_i at [i*ELEM_WIDTH +: ELEM_WIDTH]
//   error      : fault level, held until cleared by input_done in ERR
//   ready      : one-cycle pulse after a full set is confirmed
//   count      : number of complete pairs captured
//
// Build option:
//   SAMPLE_LOADER_RANGE_CHECK_EN - when defined, an entered value above
//   MAX_VALUE in LOAD_X / LOAD_Y is not stored and raises error.
// ---------------------------------------------------------------------------
module sample_loader
  import linreg_pkg::*;
#(
  parameter int ELEM_WIDTH  = ELEM_WIDTH_DEF,
  parameter int NUM_SAMPLES = NUM_SAMPLES_DEF,
  parameter int MAX_VALUE   = 99
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enter,
  input  logic                                input_done,
  input  logic [ELEM_WIDTH-1:0]               data_in,
  output logic [NUM_SAMPLES*2*ELEM_WIDTH-1:0] x_data,
  output logic [NUM_SAMPLES*ELEM_WIDTH-1:0]   y_data,
  output logic                                error,
  output logic                                ready,
  output logic [$clog2(NUM_SAMPLES+1)-1:0]    count
);

  localparam int CW = $clog2(NUM_SAMPLES + 1);

  localparam logic [CW-1:0]         FULL_COUNT = CW'(NUM_SAMPLES);
  localparam logic [CW-1:0]         ONE_COUNT  = CW'(1);
  localparam logic [CW-1:0]         ZERO_COUNT = CW'(0);
  localparam logic [ELEM_WIDTH-1:0] ONE_VAL    = ELEM_WIDTH'(ONE_ELEM);
  localparam logic [ELEM_WIDTH-1:0] MAX_ELEM   = ELEM_WIDTH'(MAX_VALUE);

`ifdef SAMPLE_LOADER_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  logic enter_rise_s;
  logic done_rise_s;
  logic over_range_s;

  loader_state_t state_r;
  loader_state_t state_nxt_s;

  logic [NUM_SAMPLES*2*ELEM_WIDTH-1:0] x_data_r;
  logic [NUM_SAMPLES*ELEM_WIDTH-1:0]   y_data_r;
  logic [CW-1:0]                       count_r;
  logic                                error_r;
  logic                                ready_r;

  // Datapath control strobes decoded from the FSM.
  logic          wr_x_s;
  logic          wr_y_s;
  logic          clr_data_s;
  logic          set_err_s;
  logic          clr_err_s;
  logic          ready_set_s;
  logic [CW-1:0] wr_idx_s;
  logic [CW-1:0] count_inc_s;

  rise_detect u_enter_rise (
    .clk  (clk),
    .rst  (rst),
    .sig  (enter),
    .rise (enter_rise_s)
  );

  rise_detect u_done_rise (
    .clk  (clk),
    .rst  (rst),
    .sig  (input_done),
    .rise (done_rise_s)
  );

  // The comparison disappears in builds without the range check.
  assign over_range_s = RANGE_CHECK && (data_in > MAX_ELEM);
  assign count_inc_s  = count_r + ONE_COUNT;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= LOAD_X;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; an input_done edge always wins over an enter edge.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      LOAD_X: begin
        if (done_rise_s) begin
          state_nxt_s = ERR;
        end else if (enter_rise_s) begin
          if (over_range_s) begin
            state_nxt_s = ERR;
          end else begin
            state_nxt_s = LOAD_Y;
          end
        end else begin
          state_nxt_s = LOAD_X;
        end
      end
      LOAD_Y: begin
        if (done_rise_s) begin
          state_nxt_s = ERR;
        end else if (enter_rise_s) begin
          if (over_range_s) begin
            state_nxt_s = ERR;
          end else if (count_inc_s == FULL_COUNT) begin
            state_nxt_s = FULL;
          end else begin
            state_nxt_s = LOAD_X;
          end
        end else begin
          state_nxt_s = LOAD_Y;
        end
      end
      FULL: begin
        if (done_rise_s) begin
          state_nxt_s = DONE;
        end else if (enter_rise_s) begin
          state_nxt_s = ERR;
        end else begin
          state_nxt_s = FULL;
        end
      end
      DONE: begin
        // A simultaneous input_done edge swallows the enter edge here too.
        if (done_rise_s) begin
          state_nxt_s = DONE;
        end else if (enter_rise_s) begin
          state_nxt_s = LOAD_Y;
        end else begin
          state_nxt_s = DONE;
        end
      end
      ERR: begin
        if (done_rise_s) begin
          state_nxt_s = LOAD_X;
        end else begin
          state_nxt_s = ERR;
        end
      end
      default: begin
        state_nxt_s = LOAD_X;
      end
    endcase
  end

  // FSM output decode: datapath strobes for the current state and edges.
  always_comb begin
    wr_x_s      = 1'b0;
    wr_y_s      = 1'b0;
    clr_data_s  = 1'b0;
    set_err_s   = 1'b0;
    clr_err_s   = 1'b0;
    ready_set_s = 1'b0;
    case (state_r)
      LOAD_X: begin
        if (done_rise_s) begin
          set_err_s = 1'b1;
        end else if (enter_rise_s) begin
          if (over_range_s) begin
            set_err_s = 1'b1;
          end else begin
            wr_x_s = 1'b1;
          end
        end else begin
          wr_x_s = 1'b0;
        end
      end
      LOAD_Y: begin
        if (done_rise_s) begin
          set_err_s = 1'b1;
        end else if (enter_rise_s) begin
          if (over_range_s) begin
            set_err_s = 1'b1;
          end else begin
            wr_y_s = 1'b1;
          end
        end else begin
          wr_y_s = 1'b0;
        end
      end
      FULL: begin
        if (done_rise_s) begin
          ready_set_s = 1'b1;
        end else if (enter_rise_s) begin
          set_err_s = 1'b1;
        end else begin
          ready_set_s = 1'b0;
        end
      end
      DONE: begin
        // New set: wipe the previous one and capture this value as x_0.
        if (done_rise_s) begin
          clr_data_s = 1'b0;
        end else if (enter_rise_s) begin
          clr_data_s = 1'b1;
          wr_x_s     = 1'b1;
        end else begin
          clr_data_s = 1'b0;
        end
      end
      ERR: begin
        if (done_rise_s) begin
          clr_err_s  = 1'b1;
          clr_data_s = 1'b1;
        end else begin
          clr_err_s = 1'b0;
        end
      end
      default: begin
        clr_data_s = 1'b0;
      end
    endcase
  end

  // Row written by an x capture; a restart from DONE always targets row 0.
  always_comb begin
    if (clr_data_s) begin
      wr_idx_s = ZERO_COUNT;
    end else begin
      wr_idx_s = count_r;
    end
  end

  // Sample storage and pair counter. Later writes in this block override
  // the clear for the row being captured in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_data_r <= '0;
      y_data_r <= '0;
      count_r  <= ZERO_COUNT;
    end else begin
      if (clr_data_s) begin
        x_data_r <= '0;
        y_data_r <= '0;
        count_r  <= ZERO_COUNT;
      end
      for (int i = 0; i < NUM_SAMPLES; i++) begin
        if (wr_x_s && (CW'(i) == wr_idx_s)) begin
          x_data_r[(2*i)*ELEM_WIDTH +: ELEM_WIDTH]   <= data_in;
          x_data_r[(2*i+1)*ELEM_WIDTH +: ELEM_WIDTH] <= ONE_VAL;
        end
        if (wr_y_s && (CW'(i) == count_r)) begin
          y_data_r[i*ELEM_WIDTH +: ELEM_WIDTH] <= data_in;
        end
      end
      if (wr_y_s) begin
        count_r <= count_inc_s;
      end
    end
  end

  // Error flag and the registered ready pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_r <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      if (set_err_s) begin
        error_r <= 1'b1;
      end else if (clr_err_s) begin
        error_r <= 1'b0;
      end
      ready_r <= ready_set_s;
    end
  end

  assign x_data = x_data_r;
  assign y_data = y_data_r;
  assign count  = count_r;
  assign error  = error_r;
  assign ready  = ready_r;

endmodule

// File: tb/tb_sample_loader.sv
// ---------------------------------------------------------------------------
// tb_sample_loader
// Directed self-checking bench for sample_loader with hand-computed
// expected values for x_data, y_data, count, error and ready.
// ---------------------------------------------------------------------------
module tb_sample_loader;

  localparam int EW = 14;
  localparam int NS = 3;
  localparam int CW = $clog2(NS + 1);

  logic               clk;
  logic               rst;
  logic               enter;
  logic               input_done;
  logic [EW-1:0]      data_in;
  logic [NS*2*EW-1:0] x_data;
  logic [NS*EW-1:0]   y_data;
  logic               error;
  logic               ready;
  logic [CW-1:0]      count;

  int chk_cnt;
  int pass_cnt;

  sample_loader #(
    .ELEM_WIDTH  (EW),
    .NUM_SAMPLES (NS),
    .MAX_VALUE   (99)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enter      (enter),
    .input_done (input_done),
    .data_in    (data_in),
    .x_data     (x_data),
    .y_data     (y_data),
    .error      (error),
    .ready      (ready),
    .count      (count)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs,
                           input logic [127:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_enter(input logic [EW-1:0] v);
    data_in = v;
    enter   = 1'b1;
    tick();
    enter = 1'b0;
    tick();
  endtask

  task automatic press_done();
    input_done = 1'b1;
    tick();
    input_done = 1'b0;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_x"}, x_data, '0);
    check_val({tag, "_y"}, y_data, '0);
    check_val({tag, "_count"}, count, '0);
    check_val({tag, "_error"}, error, '0);
    check_val({tag, "_ready"}, ready, '0);
  endtask

  initial begin
    logic [NS*2*EW-1:0] x_exp;
    logic [NS*EW-1:0]   y_exp;
    int                 ready_seen;

    chk_cnt    = 0;
    pass_cnt   = 0;
    rst        = 1'b1;
    enter      = 1'b0;
    input_done = 1'b0;
    data_in    = 14'd0;

    // Reset state.
    repeat (3) tick();
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Nominal load: 8,9,5,6,2,3 then confirm.
    press_enter(14'd8);
    press_enter(14'd9);
    press_enter(14'd5);
    press_enter(14'd6);
    press_enter(14'd2);
    press_enter(14'd3);
    check_val("nom_x", x_data, {14'd1, 14'd2, 14'd1, 14'd5, 14'd1, 14'd8});
    check_val("nom_y", y_data, {14'd3, 14'd6, 14'd9});
    check_val("nom_count", count, 2'd3);
    check_val("nom_ready_before", ready, 1'b0);
    input_done = 1'b1;
    tick();
    check_val("nom_ready_pulse", ready, 1'b1);
    tick();
    check_val("nom_ready_one_cycle", ready, 1'b0);
    input_done = 1'b0;
    tick();
    check_val("nom_ready_after", ready, 1'b0);
    check_val("nom_x_held", x_data, {14'd1, 14'd2, 14'd1, 14'd5, 14'd1, 14'd8});
    check_val("nom_error", error, 1'b0);

    // Held button from DONE: only one capture, new set starts at x_0.
    data_in = 14'd7;
    enter   = 1'b1;
    repeat (20) tick();
    enter = 1'b0;
    tick();
    check_val("held_x", x_data, {14'd0, 14'd0, 14'd0, 14'd0, 14'd1, 14'd7});
    check_val("held_y", y_data, '0);
    check_val("held_count", count, 2'd0);
    press_enter(14'd5);  // lands as y_0 only if the FSM sat in LOAD_Y
    check_val("held_y0", y_data, {14'd0, 14'd0, 14'd5});
    check_val("held_count1", count, 2'd1);

    // Early done: two pairs then input_done -> error, no ready.
    press_enter(14'd4);
    press_enter(14'd5);
    check_val("early_count", count, 2'd2);
    ready_seen = 0;
    input_done = 1'b1;
    tick();
    if (ready) ready_seen++;
    input_done = 1'b0;
    tick();
    if (ready) ready_seen++;
    check_val("early_error", error, 1'b1);
    check_val("early_no_ready", ready_seen, 0);
    press_done();
    check_val("early_clr_error", error, 1'b0);
    check_val("early_clr_count", count, 2'd0);
    check_val("early_clr_x", x_data, '0);

    // Overflow: three pairs then one more enter.
    press_enter(14'd10);
    press_enter(14'd11);
    press_enter(14'd20);
    press_enter(14'd21);
    press_enter(14'd30);
    press_enter(14'd31);
    x_exp = {14'd1, 14'd30, 14'd1, 14'd20, 14'd1, 14'd10};
    y_exp = {14'd31, 14'd21, 14'd11};
    check_val("ovf_error_before", error, 1'b0);
    press_enter(14'd1);
    check_val("ovf_error", error, 1'b1);
    check_val("ovf_x_kept", x_data, x_exp);
    check_val("ovf_y_kept", y_data, y_exp);
    check_val("ovf_count_kept", count, 2'd3);
    press_done();
    check_val("ovf_clr_error", error, 1'b0);
    check_val("ovf_clr_y", y_data, '0);

    // Range boundary: 100 is one above MAX_VALUE.
    press_enter(14'd100);
`ifdef SAMPLE_LOADER_RANGE_CHECK_EN
    check_val("range_error", error, 1'b1);
    check_val("range_x", x_data, '0);
`else
    check_val("range_error", error, 1'b0);
    check_val("range_x", x_data, {14'd0, 14'd0, 14'd0, 14'd0, 14'd1, 14'd100});
`endif

    // Simultaneous edges in LOAD_Y: input_done wins, y_0 not stored.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("rst_pulse");
    @(negedge clk);
    rst = 1'b0;
    tick();
    press_enter(14'd4);
    data_in    = 14'd55;
    enter      = 1'b1;
    input_done = 1'b1;
    tick();
    enter      = 1'b0;
    input_done = 1'b0;
    tick();
    check_val("simul_error", error, 1'b1);
    check_val("simul_y", y_data, '0);
    check_val("simul_count", count, 2'd0);
    check_val("simul_x", x_data, {14'd0, 14'd0, 14'd0, 14'd0, 14'd1, 14'd4});
    press_done();
    check_val("simul_clr_error", error, 1'b0);

    // Reset mid-load clears everything without waiting for a clock edge.
    press_enter(14'd12);
    press_enter(14'd13);
    press_enter(14'd14);
    check_val("mid_count", count, 2'd1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    // A level already high at reset release is seen as an edge.
    data_in = 14'd9;
    enter   = 1'b1;
    repeat (2) tick();
    check_val("rst_held_x", x_data, '0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_val("rel_edge_x", x_data, {14'd0, 14'd0, 14'd0, 14'd0, 14'd1, 14'd9});
    enter = 1'b0;
    tick();
    check_val("rel_edge_count", count, 2'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
